// File: rtl/gf_bitserial_mult_ctrl_pkg.sv
// gf_bitserial_mult_ctrl_pkg: shared width default, FSM encoding and reference polynomial
package gf_bitserial_mult_ctrl_pkg;
  localparam int M_DEF = 32;
  localparam logic [31:0] GF_POLY32 = 32'h0040_0007;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
endpackage

// File: rtl/gf_bitserial_mult_ctrl_if.sv
// gf_bitserial_mult_ctrl_if: operand/result handshake bundle for the bit-serial multiplier
interface gf_bitserial_mult_ctrl_if
  import gf_bitserial_mult_ctrl_pkg::*;
#(
  parameter int M = M_DEF
);
  logic         in_valid;
  logic         in_ready;
  logic [M-1:0] a_in;
  logic [M-1:0] b_in;
  logic [M-1:0] g_in;
  logic         out_valid;
  logic         out_ready;
  logic [M-1:0] p_out;
  logic         busy;
  modport master (
    output in_valid, a_in, b_in, g_in, out_ready,
    input  in_ready, out_valid, p_out, busy
  );
  modport slave (
    input  in_valid, a_in, b_in, g_in, out_ready,
    output in_ready, out_valid, p_out, busy
  );
endinterface

// File: rtl/gf_bitserial_mult_ctrl_row_step.sv
// gf_row_step: one systolic row of a GF(2^M) multiply, shift-and-reduce with optional A add
module gf_row_step #(
  parameter int M = 32
) (
  input  logic [M-1:0] p_i,
  input  logic [M-1:0] a_i,
  input  logic [M-1:0] g_i,
  input  logic         b_i,
  output logic [M-1:0] p_o
);
  assign p_o = {p_i[M-2:0], 1'b0} ^ (b_i ? a_i : '0) ^ (p_i[M-1] ? g_i : '0);
endmodule

// File: rtl/gf_bitserial_mult_ctrl.sv
// gf_bitserial_mult_ctrl: bit-serial GF(2^M) multiplier, one row step per clock, B fed MSB-first
module gf_bitserial_mult_ctrl
  import gf_bitserial_mult_ctrl_pkg::*;
#(
  parameter int M = M_DEF
) (
  input logic clk,
  input logic rst_n,
  gf_bitserial_mult_ctrl_if.slave bus
);
  localparam int CW = $clog2(M);
  state_e        state_q, state_d;
  logic [M-1:0]  a_q, a_d, b_q, b_d, g_q, g_d, p_q, p_d, step_p;
  logic [CW-1:0] cnt_q, cnt_d;
  gf_row_step #(.M(M)) u_step (
    .p_i(p_q),
    .a_i(a_q),
    .g_i(g_q),
    .b_i(b_q[cnt_q]),
    .p_o(step_p)
  );
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      g_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      g_q     <= g_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    g_d     = g_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.a_in;
        b_d     = bus.b_in;
        g_d     = bus.g_in;
        p_d     = '0;
        cnt_d   = CW'(M - 1);
        state_d = RUN;
      end
      RUN: begin
        p_d     = step_p;
        cnt_d   = cnt_q == '0 ? cnt_q : cnt_q - 1'b1;
        state_d = cnt_q == '0 ? DONE : RUN;
      end
      DONE: state_d = bus.out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  // p_out is gated so nothing but a finished product ever appears on the bus
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == DONE;
  assign bus.p_out     = state_q == DONE ? p_q : '0;
  assign bus.busy      = state_q == RUN || state_q == DONE;
endmodule

// File: tb/tb_gf_bitserial_mult_ctrl.sv
// tb_gf_bitserial_mult_ctrl: directed and randomized checks of the bit-serial GF multiplier
module tb_gf_bitserial_mult_ctrl;
  import gf_bitserial_mult_ctrl_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int cmp = 0;
  int errs = 0;
  gf_bitserial_mult_ctrl_if #(.M(8))  b8();
  gf_bitserial_mult_ctrl_if #(.M(32)) b32();
  gf_bitserial_mult_ctrl #(.M(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  gf_bitserial_mult_ctrl #(.M(32)) dut32 (.clk(clk), .rst_n(rst_n), .bus(b32.slave));
  always #5 clk = ~clk;
  // carry-less product followed by long division by x^32 + g
  function automatic logic [31:0] gfmul(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g);
    logic [63:0] prod;
    logic [63:0] poly;
    prod = '0;
    poly = {31'b0, 1'b1, g};
    for (int i = 0; i < 32; i++) if (b[i]) prod = prod ^ (64'(a) << i);
    for (int i = 62; i >= 32; i--) if (prod[i]) prod = prod ^ (poly << (i - 32));
    return prod[31:0];
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic start32(input logic [31:0] a, input logic [31:0] b, input logic [31:0] g);
    b32.a_in = a;
    b32.b_in = b;
    b32.g_in = g;
    b32.in_valid = 1'b1;
    tick;
    b32.in_valid = 1'b0;
  endtask
  task automatic wait_done32(output int n);
    n = 0;
    while (!b32.out_valid && n < 200) begin
      tick;
      n++;
    end
  endtask
  task automatic release32;
    b32.out_ready = 1'b1;
    tick;
    b32.out_ready = 1'b0;
  endtask
  task automatic check_idle(input string name);
    cmp++;
    if (b32.in_ready !== 1'b1 || b32.out_valid !== 1'b0 || b32.p_out !== 32'h0 || b32.busy !== 1'b0) begin
      errs++;
      $display("FAIL %s: rdy=%b vld=%b p=%h busy=%b, required rdy=1 vld=0 p=0 busy=0",
               name, b32.in_ready, b32.out_valid, b32.p_out, b32.busy);
    end
  endtask
  task automatic run_vec(input string name, input logic [31:0] a, input logic [31:0] b, input logic [31:0] g);
    int n;
    logic [31:0] exp_p;
    exp_p = gfmul(a, b, g);
    start32(a, b, g);
    wait_done32(n);
    cmp++;
    if (n !== 32 || b32.p_out !== exp_p) begin
      errs++;
      $display("FAIL %s: p=%h lat=%0d, required p=%h lat=32", name, b32.p_out, n, exp_p);
    end
    release32;
  endtask
  task automatic test_reset;
    b8.in_valid = 0; b8.out_ready = 0; b8.a_in = 0; b8.b_in = 0; b8.g_in = 0;
    b32.in_valid = 0; b32.out_ready = 0; b32.a_in = 0; b32.b_in = 0; b32.g_in = 0;
    repeat (3) tick;
    check_idle("reset32");
    cmp++;
    if (b8.in_ready !== 1'b1 || b8.out_valid !== 1'b0 || b8.p_out !== 8'h0 || b8.busy !== 1'b0) begin
      errs++;
      $display("FAIL reset8: rdy=%b vld=%b p=%h busy=%b, required 1 0 00 0", b8.in_ready, b8.out_valid, b8.p_out, b8.busy);
    end
    rst_n = 1'b1;
    tick;
    check_idle("after_release");
  endtask
  task automatic test_aes8;
    int n;
    b8.a_in = 8'h57; b8.b_in = 8'h83; b8.g_in = 8'h1B;
    b8.in_valid = 1'b1;
    tick;
    b8.in_valid = 1'b0;
    b8.a_in = 8'hFF; b8.b_in = 8'hFF;
    n = 0;
    while (!b8.out_valid && n < 100) begin
      tick;
      n++;
    end
    cmp++;
    if (n !== 8 || b8.p_out !== 8'hC1) begin
      errs++;
      $display("FAIL aes8: p=%h lat=%0d, required p=c1 lat=8", b8.p_out, n);
    end
    b8.out_ready = 1'b1;
    tick;
    b8.out_ready = 1'b0;
    cmp++;
    if (b8.out_valid !== 1'b0 || b8.in_ready !== 1'b1 || b8.p_out !== 8'h0) begin
      errs++;
      $display("FAIL aes8_release: vld=%b rdy=%b p=%h, required 0 1 00", b8.out_valid, b8.in_ready, b8.p_out);
    end
  endtask
  task automatic test_vectors;
    run_vec("x_times_x31", 32'h2, 32'h8000_0000, GF_POLY32);
    cmp++;
    if (gfmul(32'h2, 32'h8000_0000, GF_POLY32) !== 32'h0040_0007) begin
      errs++;
      $display("FAIL model_x32: got %h, required 00400007", gfmul(32'h2, 32'h8000_0000, GF_POLY32));
    end
    run_vec("b_zero", 32'hFFFF_FFFF, 32'h0, GF_POLY32);
    run_vec("a_one", 32'h1, 32'h1234_5678, GF_POLY32);
    run_vec("g_zero", 32'hDEAD_BEEF, 32'hF00D_1234, 32'h0);
    run_vec("all_ones", 32'hFFFF_FFFF, 32'hFFFF_FFFF, GF_POLY32);
  endtask
  task automatic test_hold;
    int n;
    logic [31:0] a, b, g, a2, b2, g2, exp_p, exp2;
    a = $urandom; b = $urandom; g = $urandom;
    a2 = $urandom; b2 = $urandom; g2 = $urandom;
    exp_p = gfmul(a, b, g);
    exp2 = gfmul(a2, b2, g2);
    start32(a, b, g);
    wait_done32(n);
    b32.a_in = a2; b32.b_in = b2; b32.g_in = g2;
    b32.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cmp++;
      if (b32.p_out !== exp_p || b32.out_valid !== 1'b1 || b32.in_ready !== 1'b0 || b32.busy !== 1'b1) begin
        errs++;
        $display("FAIL hold[%0d]: p=%h vld=%b rdy=%b busy=%b, required p=%h 1 0 1", i, b32.p_out, b32.out_valid, b32.in_ready, b32.busy, exp_p);
      end
      tick;
    end
    b32.out_ready = 1'b1;
    tick;
    b32.out_ready = 1'b0;
    check_idle("hold_release");
    tick;
    b32.in_valid = 1'b0;
    cmp++;
    if (b32.busy !== 1'b1 || b32.in_ready !== 1'b0) begin
      errs++;
      $display("FAIL hold_next_accept: busy=%b rdy=%b, required 1 0", b32.busy, b32.in_ready);
    end
    wait_done32(n);
    cmp++;
    if (n !== 32 || b32.p_out !== exp2) begin
      errs++;
      $display("FAIL hold_next_result: p=%h lat=%0d, required p=%h lat=32", b32.p_out, n, exp2);
    end
    release32;
  endtask
  task automatic test_reset_midrun;
    start32(32'hA5A5_0F0F, 32'hFFFF_0001, GF_POLY32);
    repeat (10) tick;
    cmp++;
    if (b32.busy !== 1'b1) begin
      errs++;
      $display("FAIL midrun_busy: busy=%b, required 1", b32.busy);
    end
    #2 rst_n = 1'b0;
    #1 check_idle("async_reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    tick;
    check_idle("post_reset_idle");
    run_vec("post_reset_x32", 32'h2, 32'h8000_0000, GF_POLY32);
  endtask
  task automatic test_random(input int nops);
    logic [31:0] expq[$];
    int got = 0;
    fork
      begin
        for (int i = 0; i < nops; i++) begin
          int w;
          logic [31:0] a, b, g;
          repeat ($urandom_range(0, 2)) tick;
          a = $urandom; b = $urandom; g = $urandom;
          b32.a_in = a; b32.b_in = b; b32.g_in = g;
          b32.in_valid = 1'b1;
          w = 0;
          while (!b32.in_ready && w < 200) begin
            tick;
            w++;
          end
          if (w >= 200) begin
            cmp++;
            errs++;
            $display("FAIL rand_accept_timeout: op %0d never accepted", i);
            break;
          end
          expq.push_back(gfmul(a, b, g));
          tick;
          b32.in_valid = 1'b0;
        end
      end
      begin
        int cyc = 0;
        while (got < nops && cyc < 80000) begin
          b32.out_ready = 1'($urandom_range(0, 1));
          if (b32.out_valid && b32.out_ready) begin
            cmp++;
            if (expq.size() == 0) begin
              errs++;
              $display("FAIL rand_dup: result %h with no outstanding op", b32.p_out);
            end else if (b32.p_out !== expq[0]) begin
              errs++;
              $display("FAIL rand_result[%0d]: p=%h, required %h", got, b32.p_out, expq[0]);
            end
            if (expq.size() != 0) void'(expq.pop_front());
            got++;
          end
          tick;
          cyc++;
        end
        b32.out_ready = 1'b0;
      end
    join
    cmp++;
    if (got !== nops || expq.size() !== 0) begin
      errs++;
      $display("FAIL rand_count: got=%0d pending=%0d, required got=%0d pending=0", got, expq.size(), nops);
    end
    repeat (3) tick;
    check_idle("rand_drain");
  endtask
  initial begin
    test_reset;
    test_aes8;
    test_vectors;
    test_hold;
    test_reset_midrun;
    test_random(800);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
    $finish;
  end
endmodule
